// File: rtl/io_bus_bridge.sv
`timescale 1ns/1ps
// io_bus_bridge
//   Bridges a simple level-request master bus onto four memory-mapped slaves.
//   Each slave owns a 256-byte window at 0x40000n00 (n = 0..3). Addresses whose
//   bits [11:10] are not zero are unmapped and are answered directly with an
//   error. A slave that never raises s_ready is abandoned after TIMEOUT_CYC
//   cycles and the master receives an error response.
//
// Ports
//   clk, rst_n     clock (rising edge); asynchronous active-low reset
//   b_addr_i       master byte address; only [11:2] are used
//   b_data_i       master write data
//   b_read_i       master read request (level, held until ack)
//   b_write_i      master write request (level, held until ack)
//   b_data_o       response data, non-zero only in the ack cycle
//   b_ack_o        one-cycle completion pulse
//   s_sel          one-hot slave select, registered
//   s_we           slave write qualifier, registered
//   s_addr         word-aligned offset within the slave window
//   s_wdata        slave write data
//   s_rdata        packed slave read data, slave n on [32n+31:32n]
//   s_ready        per-slave completion
//   err_o          sticky error flag, cleared only by reset
module io_bus_bridge #(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   b_addr_i,
    input  logic [31:0]   b_data_i,
    input  logic          b_read_i,
    input  logic          b_write_i,
    output logic [31:0]   b_data_o,
    output logic          b_ack_o,
    output logic [3:0]    s_sel,
    output logic          s_we,
    output logic [7:0]    s_addr,
    output logic [31:0]   s_wdata,
    input  logic [127:0]  s_rdata,
    input  logic [3:0]    s_ready,
    output logic          err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       slot;
    logic [31:0]      resp_data;

    logic req;
    logic conflict;
    logic mapped;
    logic hit;
    logic timeout;

    assign req      = b_read_i | b_write_i;
    assign conflict = b_read_i & b_write_i;
    assign mapped   = (b_addr_i[11:10] == 2'b00);
    // Only the slave actually selected can complete the access.
    assign hit      = s_ready[slot];
    assign timeout  = (cnt == CNT_LAST);

    // Upper address bits are pre-decoded by the master; byte offset is ignored.
    logic unused_addr;
    assign unused_addr = ^{b_addr_i[31:12], b_addr_i[1:0]};

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = (mapped && !conflict) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (hit || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request capture, slave drive, timeout count and response
    // formation. The response word and the error flag are loaded on the edge
    // that enters RESP so both are already valid during the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            slot      <= '0;
            s_sel     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            resp_data <= '0;
            err_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        cnt     <= '0;
                        slot    <= b_addr_i[9:8];
                        s_addr  <= {b_addr_i[7:2], 2'b00};
                        s_wdata <= b_data_i;
                        if (mapped && !conflict) begin
                            s_sel <= 4'b0001 << b_addr_i[9:8];
                            s_we  <= b_write_i;
                        end else begin
                            // Unmapped or read+write conflict: answer at once.
                            err_o     <= 1'b1;
                            resp_data <= (b_write_i && !b_read_i) ? 32'h0 : ERR_DATA;
                        end
                    end
                end
                ACCESS: begin
                    if (hit) begin
                        resp_data <= s_we ? 32'h0 : s_rdata[{slot, 5'b00000} +: 32];
                        s_sel     <= '0;
                        s_we      <= 1'b0;
                    end else if (timeout) begin
                        resp_data <= s_we ? 32'h0 : ERR_DATA;
                        err_o     <= 1'b1;
                        s_sel     <= '0;
                        s_we      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign b_ack_o  = (state == RESP);
    assign b_data_o = (state == RESP) ? resp_data : 32'h0;

endmodule

// File: tb/tb_io_bus_bridge.sv
`timescale 1ns/1ps
// tb_io_bus_bridge
//   Self-checking bench for io_bus_bridge. Each transaction is predicted from
//   the bridge's behavioural rules (ack cycle, response word, select pattern,
//   sticky error) before it is driven; outputs are sampled on the falling
//   edge, inputs are driven on the falling edge.
module tb_io_bus_bridge;

    localparam int unsigned TIMEOUT_CYC = 256;
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;
    localparam int          NEVER       = 100000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   b_addr_i;
    logic [31:0]   b_data_i;
    logic          b_read_i;
    logic          b_write_i;
    logic [31:0]   b_data_o;
    logic          b_ack_o;
    logic [3:0]    s_sel;
    logic          s_we;
    logic [7:0]    s_addr;
    logic [31:0]   s_wdata;
    logic [127:0]  s_rdata;
    logic [3:0]    s_ready;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int last_ack = 0;
    logic err_exp = 1'b0;

    io_bus_bridge #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .ERR_DATA    (ERR_DATA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_addr_i  (b_addr_i),
        .b_data_i  (b_data_i),
        .b_read_i  (b_read_i),
        .b_write_i (b_write_i),
        .b_data_o  (b_data_o),
        .b_ack_o   (b_ack_o),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Runs one master transaction.
    //   addr     : low 12 address bits (upper bits are always 0x40000)
    //   d        : ACCESS cycles before the selected slave raises s_ready
    //   drop_at  : cycle from which the master abandons its request (NEVER = hold)
    //   slv_word : read word presented by the selected slave
    task automatic run_txn(input logic [11:0] addr, input logic [31:0] wdata,
                           input logic rd, input logic wr, input int d,
                           input int drop_at, input logic [31:0] slv_word);
        logic [1:0]  slot;
        logic        good;
        logic        err_txn;
        int          ack_exp;
        logic [31:0] exp_data;
        logic [3:0]  exp_sel;
        logic [127:0] rdata;
        logic        in_acc;

        slot    = addr[9:8];
        good    = (addr[11:10] == 2'b00) && !(rd && wr);
        ack_exp = !good ? 1 : (d < int'(TIMEOUT_CYC) ? d + 2 : int'(TIMEOUT_CYC) + 1);
        err_txn = !good || (d >= int'(TIMEOUT_CYC));
        if (wr && !rd)   exp_data = 32'h0;
        else if (err_txn) exp_data = ERR_DATA;
        else             exp_data = slv_word;
        exp_sel = 4'b0001 << slot;

        @(negedge clk);
        check("idle_ack", {31'b0, b_ack_o}, 32'd0);
        check("idle_data", b_data_o, 32'h0);
        check("idle_sel", {28'b0, s_sel}, 32'd0);
        b_addr_i  = {20'h40000, addr};
        b_data_i  = wdata;
        b_read_i  = rd;
        b_write_i = wr;
        s_ready   = 4'b0000;

        for (int cyc = 1; cyc <= ack_exp; cyc++) begin
            @(negedge clk);
            in_acc = good && (cyc < ack_exp);
            check("ack", {31'b0, b_ack_o}, {31'b0, cyc == ack_exp});
            check("data", b_data_o, (cyc == ack_exp) ? exp_data : 32'h0);
            check("sel", {28'b0, s_sel}, in_acc ? {28'b0, exp_sel} : 32'd0);
            check("err", {31'b0, err_o}, {31'b0, err_exp || (err_txn && cyc == ack_exp)});
            if (in_acc) begin
                check("we", {31'b0, s_we}, {31'b0, wr});
                check("saddr", {24'b0, s_addr}, {24'b0, addr[7:2], 2'b00});
                check("swdata", s_wdata, wdata);
            end
            if (cyc == ack_exp) begin
                last_ack  = cyc_cnt;
                b_read_i  = 1'b0;
                b_write_i = 1'b0;
                s_ready   = 4'b0000;
                err_exp   = err_exp | err_txn;
            end else begin
                if (cyc >= drop_at) begin
                    b_read_i  = 1'b0;
                    b_write_i = 1'b0;
                    b_addr_i  = $urandom;
                    b_data_i  = $urandom;
                end
                // Unselected slaves may chatter; only the selected one counts.
                s_ready = 4'($urandom) & ~exp_sel;
                s_ready[slot] = ((cyc - 1) == d);
                rdata = {$urandom, $urandom, $urandom, $urandom};
                rdata[32*slot +: 32] = slv_word;
                s_rdata = rdata;
            end
        end
    endtask

    initial begin
        logic [11:0] a;
        logic        rd;
        logic        wr;
        int          d;
        int          drop;
        int          t_first;
        int          r;

        rst_n     = 1'b0;
        b_addr_i  = '0;
        b_data_i  = '0;
        b_read_i  = 1'b0;
        b_write_i = 1'b0;
        s_rdata   = '0;
        s_ready   = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, b_ack_o}, 32'd0);
        check("rst_sel", {28'b0, s_sel}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_saddr", {24'b0, s_addr}, 32'd0);
        rst_n = 1'b1;

        // Good read, immediate ready (first request right after reset release).
        run_txn(12'h104, 32'h0, 1'b1, 1'b0, 0, NEVER, 32'h1234_5678);
        // Write to slave 3, ready after 5 cycles.
        run_txn(12'h308, 32'hA5A5_0F0F, 1'b0, 1'b1, 5, NEVER, 32'hFFFF_FFFF);

        // Back-to-back reads, slaves 0 then 1: acks three cycles apart.
        run_txn(12'h010, 32'h0, 1'b1, 1'b0, 0, NEVER, 32'h0BAD_F00D);
        t_first = last_ack;
        run_txn(12'h1FC, 32'h0, 1'b1, 1'b0, 0, NEVER, 32'hC0FF_EE01);
        check("b2b_gap", last_ack - t_first, 32'd3);

        // Request dropped mid-access: bridge still completes and acks.
        run_txn(12'h220, 32'h0, 1'b1, 1'b0, 3, 2, 32'h5555_AAAA);

        // Ready on the final allowed cycle still succeeds.
        run_txn(12'h200, 32'h0, 1'b1, 1'b0, TIMEOUT_CYC - 1, NEVER, 32'h7777_1111);
        check("err_clean", {31'b0, err_o}, 32'd0);

        // Unmapped read: error response in cycle 1, err_o sticks.
        run_txn(12'h800, 32'h0, 1'b1, 1'b0, 0, NEVER, 32'h0);
        // Timeout on slave 2.
        run_txn(12'h204, 32'h0, 1'b1, 1'b0, NEVER, NEVER, 32'h0);
        // Read+write conflict.
        run_txn(12'h104, 32'h1, 1'b1, 1'b1, 0, NEVER, 32'h0);

        // Reset in the middle of an ACCESS.
        @(negedge clk);
        b_addr_i = 32'h4000_0210;
        b_read_i = 1'b1;
        @(negedge clk);
        check("mid_sel", {28'b0, s_sel}, 32'd4);
        rst_n = 1'b0;
        #1;
        check("arst_sel", {28'b0, s_sel}, 32'd0);
        check("arst_ack", {31'b0, b_ack_o}, 32'd0);
        check("arst_data", b_data_o, 32'h0);
        check("arst_err", {31'b0, err_o}, 32'd0);
        check("arst_we_addr", {23'b0, s_we, s_addr}, 32'd0);
        check("arst_wdata", s_wdata, 32'h0);
        b_read_i = 1'b0;
        s_ready  = 4'b0000;
        err_exp  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(12'h30C, 32'h0, 1'b1, 1'b0, 1, NEVER, 32'h600D_CAFE);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            a  = 12'($urandom);
            if (r < 8) a[11:10] = 2'b00;
            r  = $urandom_range(0, 9);
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            r  = $urandom_range(0, 19);
            d  = (r == 0) ? NEVER : $urandom_range(0, 6);
            r  = $urandom_range(0, 3);
            drop = (r == 0) ? $urandom_range(1, 4) : NEVER;
            run_txn(a, $urandom, rd, wr, d, drop, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 256: max cycles the bridge waits for slave s_ready before forcing an error response.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on unmapped, timed-out or conflicting accesses.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 b_addr_i  in  32  master byte address; only [11:0] decoded, [31:12] already matched 20'h40000 by the master.
REQ-006 b_data_i  in  32  master write data.
REQ-007 b_read_i / b_write_i  in  1 each  level request, held by master until ack; undriven lines are pulled low at top level.
REQ-008 b_data_o  out  32  read data to master.
REQ-009 b_ack_o  out  1  single-cycle completion pulse.
REQ-010 s_sel  out  4  one-hot slave select, slot n = address window 0x40000n00-0x40000nFF, n=0..3.
REQ-011 s_we  out  1  slave write strobe qualifier; s_addr  out  8  word-aligned offset b_addr_i[7:0]; s_wdata  out  32.
REQ-012 s_rdata  in  128  packed slave read data, slave n on [32n+31:32n]; s_ready  in  4  per-slave completion.
REQ-013 err_o  out  1  sticky error flag.

Function
REQ-014 Accesses are full-word only; b_addr_i[1:0] ignored, no byte lanes.
REQ-015 FSM states IDLE, ACCESS, RESP; RESP lasts exactly one cycle then returns to IDLE.
REQ-016 IDLE: on b_read_i|b_write_i, latch address, write data and direction, go ACCESS if b_addr_i[11:10]==0, else go RESP with error.
REQ-017 ACCESS: drive s_sel[b_addr[9:8]] high, s_we=latched write, s_addr, s_wdata held stable every cycle until exit.
REQ-018 ACCESS: when s_ready of the selected slave is 1, latch its s_rdata word and go RESP; s_ready of unselected slaves ignored.
REQ-019 ACCESS: a counter starting at 0 on entry increments each cycle; on reaching TIMEOUT_CYC-1 without s_ready, deassert s_sel, go RESP with error.
REQ-020 RESP: b_ack_o=1 for that cycle only; b_data_o = latched read data for good reads, ERR_DATA for error reads, 0 for writes.
REQ-021 b_data_o is 0 in every cycle other than RESP.
REQ-022 Minimum latency: request seen cycle 0, s_sel cycle 1, s_ready in cycle 1, b_ack_o in cycle 2; unmapped ack in cycle 1.
REQ-023 Back-to-back: a request present in the IDLE cycle immediately after RESP is a new transaction and is accepted.
REQ-024 b_read_i and b_write_i both 1 in IDLE: treated as error, no slave selected, b_data_o=ERR_DATA.
REQ-025 If the master drops its request while in ACCESS, the bridge finishes the slave cycle but still pulses b_ack_o, with no other effect.
REQ-026 err_o sets to 1 in the RESP cycle of any error (unmapped, timeout, conflict) and stays 1 until reset.
REQ-027 s_sel, s_we outputs are registered; s_sel is all-zero outside ACCESS.

Reset
REQ-028 rst_n low at any time, including mid-ACCESS: FSM to IDLE, counter 0, b_ack_o=0, b_data_o=0, s_sel=0, s_we=0, s_addr=0, s_wdata=0, err_o=0, asynchronously.
REQ-029 First request is accepted on the first rising edge with rst_n high.

Verification
REQ-030 Read 0x40000104, slave1 s_rdata=32'h1234_5678, s_ready in cycle 1 -> s_sel=4'b0010 cycle 1, b_ack_o=1, b_data_o=32'h1234_5678 cycle 2.
REQ-031 Write 0x40000308 data 32'hA5A5_0F0F, slave3 ready after 5 cycles -> s_we=1, s_addr=8'h08, s_wdata stable throughout, one ack pulse, b_data_o=0.
REQ-032 Read 0x40000800 -> no s_sel, b_ack_o cycle 1, b_data_o=32'hDEAD_BEEF, err_o=1 and stays 1.
REQ-033 Read slave2 with s_ready never asserted -> ack exactly TIMEOUT_CYC cycles after ACCESS entry, b_data_o=ERR_DATA, err_o=1.
REQ-034 Two consecutive reads to slaves 0 then 1, each ready immediately -> two acks 3 cycles apart, correct data each, no extra ack.
REQ-035 rst_n asserted mid-ACCESS -> all outputs 0 immediately, next request after release completes normally with err_o=0.
